data_memory_controller: RTL and testbench

- Sequences the byte-addressed data memory (32-bit port, 128-byte capacity, bit-masked writes, rising-edge write) on behalf of several requesters, e.g. the CPU load/store stage and a debug/loader port.
- Round-robin arbitration, one access in flight.
- Generates write masks for byte, half and word accesses, and sign- or zero-extends read data.
- Rejects misaligned or out-of-range accesses before they reach memory.

---
 rtl/data_memory_controller_pkg.sv | 39 +++
 rtl/data_memory_lane.sv | 38 +++
 rtl/data_memory_controller.sv | 175 +++++++++++++++++
 tb/tb_data_memory_controller.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_controller_pkg.sv
// Shared types and helpers for the data memory controller.
package data_memory_controller_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } ctrl_state_e;

    // Right-aligned bit mask covering the bytes touched by an access.
    function automatic logic [DATA_W-1:0] size_mask(input access_size_e size);
        case (size)
            SIZE_BYTE: size_mask = 32'h0000_00FF;
            SIZE_HALF: size_mask = 32'h0000_FFFF;
            SIZE_WORD: size_mask = 32'hFFFF_FFFF;
            default:   size_mask = '0;
        endcase
    endfunction

    // Sign- or zero-extend the low bytes of a raw memory word.
    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] data,
                                                      input access_size_e      size,
                                                      input logic              sign_ext);
        case (size)
            SIZE_BYTE: extend_load = {{24{sign_ext & data[7]}}, data[7:0]};
            SIZE_HALF: extend_load = {{16{sign_ext & data[15]}}, data[15:0]};
            default:   extend_load = data;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_lane.sv
// Mask generation, legality check and load extension for one request.
module data_memory_lane
    import data_memory_controller_pkg::*;
#(
    parameter int unsigned BitWidth  = 32,
    parameter int unsigned Capacity  = 128,
    parameter int unsigned AddrWidth = 7
) (
    input  logic [1:0]           size,
    input  logic                 sign_ext,
    input  logic [AddrWidth-1:0] addr,
    input  logic [BitWidth-1:0]  rdata,
    output logic                 legal_c,
    output logic [BitWidth-1:0]  wmask_c,
    output logic [BitWidth-1:0]  rdata_ext_c
);

    localparam int unsigned SpanW = AddrWidth + 2;

    logic [SpanW-1:0] span;
    logic [SpanW-1:0] end_addr;

    // Illegal: reserved size, misaligned address, or access running past the end.
    always_comb begin
        span     = SpanW'(1) << size;
        end_addr = SpanW'(addr) + span;
        legal_c  = (size != 2'd3)
                && ((SpanW'(addr) & (span - SpanW'(1))) == '0)
                && (end_addr <= SpanW'(Capacity));
    end

    // Write mask and extended load data for the current size.
    always_comb begin
        wmask_c     = BitWidth'(size_mask(access_size_e'(size)));
        rdata_ext_c = BitWidth'(extend_load(DATA_W'(rdata), access_size_e'(size), sign_ext));
    end

endmodule

// File: rtl/data_memory_controller.sv
// Round-robin arbiter and sequencer for a byte-addressed data memory.
module data_memory_controller
    import data_memory_controller_pkg::*;
#(
    parameter int unsigned Requesters = 2,
    parameter int unsigned BitWidth   = 32,
    parameter int unsigned Capacity   = 128,
    parameter int unsigned AddrWidth  = $clog2(Capacity)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [Requesters-1:0]                req_valid,
    output logic [Requesters-1:0]                req_ready,
    input  logic [Requesters-1:0]                req_write,
    input  logic [Requesters-1:0][1:0]           req_size,
    input  logic [Requesters-1:0]                req_signed,
    input  logic [Requesters-1:0][AddrWidth-1:0] req_addr,
    input  logic [Requesters-1:0][BitWidth-1:0]  req_wdata,
    output logic [Requesters-1:0]                rsp_valid,
    output logic                                 rsp_error,
    output logic [BitWidth-1:0]                  rsp_rdata,
    output logic                                 mem_enable,
    output logic                                 mem_write,
    output logic [AddrWidth-1:0]                 mem_addr,
    output logic [BitWidth-1:0]                  mem_wdata,
    output logic [BitWidth-1:0]                  mem_wmask,
    input  logic [BitWidth-1:0]                  mem_rdata
);

    localparam int unsigned PtrW = (Requesters > 1) ? $clog2(Requesters) : 1;

    ctrl_state_e state, state_next;

    logic [PtrW-1:0]      ptr;
    logic [PtrW-1:0]      own;
    logic                 lat_write;
    logic [1:0]           lat_size;
    logic                 lat_sign;
    logic [AddrWidth-1:0] lat_addr;
    logic [BitWidth-1:0]  lat_wdata;
    logic                 lat_err;

    logic                 win_found;
    logic [PtrW-1:0]      win_idx;
    logic [PtrW:0]        cand_sum;
    logic [1:0]           win_size;
    logic                 win_sign;
    logic [AddrWidth-1:0] win_addr;

    logic [1:0]           lane_size;
    logic                 lane_sign;
    logic [AddrWidth-1:0] lane_addr;
    logic                 lane_legal;
    logic [BitWidth-1:0]  lane_wmask;
    logic [BitWidth-1:0]  lane_rdata_ext;

    logic                 accept_c;
    logic [PtrW-1:0]      ptr_next;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        for (int unsigned k = 0; k < Requesters; k++) begin
            cand_sum = {1'b0, ptr} + (PtrW+1)'(k);
            if (cand_sum >= (PtrW+1)'(Requesters)) begin
                cand_sum = cand_sum - (PtrW+1)'(Requesters);
            end
            if (!win_found && req_valid[cand_sum[PtrW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand_sum[PtrW-1:0];
            end
        end
        win_size = req_size[win_idx];
        win_sign = req_signed[win_idx];
        win_addr = req_addr[win_idx];
    end

    assign accept_c  = (state == ST_IDLE) && win_found;
    assign ptr_next  = (win_idx == PtrW'(Requesters - 1)) ? '0 : win_idx + PtrW'(1);

    // The lane judges the incoming winner in Idle and the latched request afterwards.
    assign lane_size = (state == ST_IDLE) ? win_size : lat_size;
    assign lane_sign = (state == ST_IDLE) ? win_sign : lat_sign;
    assign lane_addr = (state == ST_IDLE) ? win_addr : lat_addr;

    data_memory_lane #(
        .BitWidth  (BitWidth),
        .Capacity  (Capacity),
        .AddrWidth (AddrWidth)
    ) u_lane (
        .size        (lane_size),
        .sign_ext    (lane_sign),
        .addr        (lane_addr),
        .rdata       (mem_rdata),
        .legal_c     (lane_legal),
        .wmask_c     (lane_wmask),
        .rdata_ext_c (lane_rdata_ext)
    );

    // State register; reset abandons any access in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus memory, handshake and response strobes.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_error  = 1'b0;
        mem_enable = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wmask  = '0;
        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    req_ready[win_idx] = 1'b1;
                    state_next = lane_legal ? ST_ACCESS : ST_RESPOND;
                end
            end
            ST_ACCESS: begin
                mem_enable = 1'b1;
                mem_write  = lat_write;
                mem_addr   = lat_addr;
                mem_wdata  = lat_wdata;
                mem_wmask  = lane_wmask;
                state_next = ST_RESPOND;
            end
            ST_RESPOND: begin
                rsp_valid[own] = 1'b1;
                rsp_error      = lat_err;
                state_next     = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture on accept, pointer advance, and load data capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            own       <= '0;
            lat_write <= 1'b0;
            lat_size  <= '0;
            lat_sign  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (accept_c) begin
                own       <= win_idx;
                lat_write <= req_write[win_idx];
                lat_size  <= win_size;
                lat_sign  <= win_sign;
                lat_addr  <= win_addr;
                lat_wdata <= req_wdata[win_idx];
                lat_err   <= !lane_legal;
                ptr       <= ptr_next;
            end
            if ((state == ST_ACCESS) && !lat_write) begin
                rsp_rdata <= lane_rdata_ext;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller with a byte-array memory model.
module tb_data_memory_controller;

    localparam int unsigned R   = 2;
    localparam int unsigned BW  = 32;
    localparam int unsigned CAP = 128;
    localparam int unsigned AW  = 7;

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic [R-1:0]         req_valid;
    logic [R-1:0]         req_ready;
    logic [R-1:0]         req_write;
    logic [R-1:0][1:0]    req_size;
    logic [R-1:0]         req_signed;
    logic [R-1:0][AW-1:0] req_addr;
    logic [R-1:0][BW-1:0] req_wdata;
    logic [R-1:0]         rsp_valid;
    logic                 rsp_error;
    logic [BW-1:0]        rsp_rdata;
    logic                 mem_enable;
    logic                 mem_write;
    logic [AW-1:0]        mem_addr;
    logic [BW-1:0]        mem_wdata;
    logic [BW-1:0]        mem_wmask;
    logic [BW-1:0]        mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mem [CAP];
    logic       mem_init = 1'b0;
    logic [AW:0] rd_ba;
    logic [AW:0] wr_ba;

    logic log_en = 1'b0;
    int   en_count = 0;
    int   g_n = 0;
    int   r_n = 0;
    int   overlap = 0;
    int   g_log [16];
    int   r_log [16];
    int   en_before;

    data_memory_controller dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_error  (rsp_error),
        .rsp_rdata  (rsp_rdata),
        .mem_enable (mem_enable),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rdata  (mem_rdata)
    );

    always #5 clock = ~clock;

    // Memory read port: little-endian bytes from addr upward; bytes past the end read 0.
    always_comb begin
        mem_rdata = 32'hA5A5_A5A5;
        rd_ba     = '0;
        if (mem_enable && !mem_write) begin
            for (int k = 0; k < 4; k++) begin
                rd_ba = {1'b0, mem_addr} + (AW+1)'(k);
                mem_rdata[8*k +: 8] = (rd_ba < (AW+1)'(CAP)) ? mem[rd_ba[AW-1:0]] : 8'h00;
            end
        end
    end

    // Memory write port, enable counter, grant and response logging.
    always @(posedge clock) begin
        if (!mem_init) begin
            for (int i = 0; i < CAP; i++) mem[i] = 8'h00;
            mem_init = 1'b1;
        end
        if (mem_enable) en_count = en_count + 1;
        if (mem_enable && mem_write) begin
            for (int k = 0; k < 4; k++) begin
                wr_ba = {1'b0, mem_addr} + (AW+1)'(k);
                if (mem_wmask[8*k] && (wr_ba < (AW+1)'(CAP))) mem[wr_ba[AW-1:0]] = mem_wdata[8*k +: 8];
            end
        end
        if (!log_en) begin
            g_n = 0;
            r_n = 0;
            overlap = 0;
        end else begin
            for (int i = 0; i < R; i++) begin
                if (req_valid[i] && req_ready[i] && g_n < 16) begin
                    g_log[g_n] = i;
                    g_n = g_n + 1;
                end
            end
            if (rsp_valid != '0 && r_n < 16) begin
                r_log[r_n] = (rsp_valid == 2'b10) ? 1 : 0;
                r_n = r_n + 1;
                if ($countones(rsp_valid) > 1) overlap = overlap + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors = vectors + 1;
        assert (obs === expv) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // One isolated transaction from requester r, checked cycle by cycle.
    task automatic txn(input string tag, input int r, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [AW-1:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rdata);
        logic [31:0] emask;
        case (sz)
            2'd0:    emask = 32'h0000_00FF;
            2'd1:    emask = 32'h0000_FFFF;
            default: emask = 32'hFFFF_FFFF;
        endcase
        @(negedge clock);
        req_write[r]  = wr;
        req_size[r]   = sz;
        req_signed[r] = sg;
        req_addr[r]   = addr;
        req_wdata[r]  = wd;
        req_valid[r]  = 1'b1;
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'(1) << r);
        @(posedge clock);
        #1;
        req_valid[r] = 1'b0;
        if (!exp_err) begin
            chk({tag, ".mem_enable"}, 32'(mem_enable), 32'd1);
            chk({tag, ".mem_write"}, 32'(mem_write), 32'(wr));
            chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr));
            chk({tag, ".mem_wmask"}, mem_wmask, emask);
            if (wr) chk({tag, ".mem_wdata"}, mem_wdata, wd);
            chk({tag, ".rsp_early"}, 32'(rsp_valid), 32'd0);
            @(posedge clock);
            #1;
        end
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(1) << r);
        chk({tag, ".rsp_error"}, 32'(rsp_error), 32'(exp_err));
        chk({tag, ".rsp_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, ".mem_idle"}, 32'(mem_enable), 32'd0);
        @(posedge clock);
        #1;
        chk({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid  = '0;
        req_write  = '0;
        req_size   = '0;
        req_signed = '0;
        req_addr   = '0;
        req_wdata  = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_error", 32'(rsp_error), 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.mem_enable", 32'(mem_enable), 32'd0);
        chk("rst.mem_write", 32'(mem_write), 32'd0);
        chk("rst.mem_wmask", mem_wmask, 32'd0);
        chk("rst.mem_addr", 32'(mem_addr), 32'd0);
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Word store/load round trip
        txn("st_w10", 0, 1'b1, 2'd2, 1'b0, 7'h10, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000);
        txn("ld_w10", 0, 1'b0, 2'd2, 1'b1, 7'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);

        // Byte store and extended loads
        txn("st_b21", 0, 1'b1, 2'd0, 1'b0, 7'h21, 32'h0000_0080, 1'b0, 32'hDEAD_BEEF);
        txn("ld_bs21", 0, 1'b0, 2'd0, 1'b1, 7'h21, 32'h0, 1'b0, 32'hFFFF_FF80);
        txn("ld_bu21", 0, 1'b0, 2'd0, 1'b0, 7'h21, 32'h0, 1'b0, 32'h0000_0080);
        txn("ld_w20", 0, 1'b0, 2'd2, 1'b0, 7'h20, 32'h0, 1'b0, 32'h0000_8000);

        // Illegal requests never reach memory; legal access ending at the last byte
        en_before = en_count;
        txn("err_h03", 0, 1'b0, 2'd1, 1'b0, 7'h03, 32'h0, 1'b1, 32'h0000_8000);
        txn("err_sz3", 0, 1'b0, 2'd3, 1'b0, 7'h00, 32'h0, 1'b1, 32'h0000_8000);
        chk("err.no_mem_enable", 32'(en_count - en_before), 32'd0);
        txn("ld_h7e", 0, 1'b0, 2'd1, 1'b0, 7'h7E, 32'h0, 1'b0, 32'h0000_0000);
        en_before = en_count;
        txn("err_w7e", 1, 1'b0, 2'd2, 1'b0, 7'h7E, 32'h0, 1'b1, 32'h0000_0000);
        chk("err_w7e.no_mem_enable", 32'(en_count - en_before), 32'd0);

        // Fairness: both requesters hold valid through six transactions
        @(negedge clock);
        log_en        = 1'b1;
        req_write     = 2'b00;
        req_size[0]   = 2'd2;
        req_signed[0] = 1'b0;
        req_addr[0]   = 7'h10;
        req_size[1]   = 2'd0;
        req_signed[1] = 1'b0;
        req_addr[1]   = 7'h21;
        req_valid     = 2'b11;
        repeat (16) @(posedge clock);
        #1;
        req_valid = 2'b00;
        repeat (2) @(posedge clock);
        #1;
        chk("rr.grants", 32'(g_n), 32'd6);
        chk("rr.responses", 32'(r_n), 32'd6);
        chk("rr.overlap", 32'(overlap), 32'd0);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr.grant%0d", i), 32'(g_log[i]), 32'(i % 2));
            chk($sformatf("rr.rsp%0d", i), 32'(r_log[i]), 32'(i % 2));
        end
        chk("rr.last_rdata", rsp_rdata, 32'h0000_0080);
        log_en = 1'b0;

        // Reset in the middle of a store's access cycle
        txn("st_w08", 0, 1'b1, 2'd2, 1'b0, 7'h08, 32'hCAFE_F00D, 1'b0, 32'h0000_0080);
        @(negedge clock);
        req_write[0]  = 1'b1;
        req_size[0]   = 2'd2;
        req_addr[0]   = 7'h08;
        req_wdata[0]  = 32'h1234_5678;
        req_valid[0]  = 1'b1;
        #1;
        chk("rst_mid.ready", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;
        req_valid = 2'b00;
        chk("rst_mid.mem_enable_pre", 32'(mem_enable), 32'd1);
        #2;
        reset = 1'b0;
        en_before = en_count;
        #1;
        chk("rst_mid.mem_enable", 32'(mem_enable), 32'd0);
        chk("rst_mid.mem_write", 32'(mem_write), 32'd0);
        chk("rst_mid.mem_wmask", mem_wmask, 32'd0);
        chk("rst_mid.mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mid.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid.rsp_rdata", rsp_rdata, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        chk("rst_mid.rsp_valid_hold", 32'(rsp_valid), 32'd0);
        chk("rst_mid.no_mem_edge", 32'(en_count - en_before), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Requester 1 alone after reset, then the pointer favours requester 0
        txn("ld_w08_r1", 1, 1'b0, 2'd2, 1'b0, 7'h08, 32'h0, 1'b0, 32'hCAFE_F00D);
        @(negedge clock);
        req_write     = 2'b00;
        req_size[0]   = 2'd2;
        req_signed[0] = 1'b0;
        req_addr[0]   = 7'h08;
        req_size[1]   = 2'd2;
        req_addr[1]   = 7'h08;
        req_valid     = 2'b11;
        #1;
        chk("ptr.ready", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;
        req_valid = 2'b00;
        @(posedge clock);
        #1;
        chk("ptr.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ptr.rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
        @(posedge clock);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
